// File: rtl/spi_sram_seq.sv
// SPI-slave sequencer: deserialises command/address/write data from synchronised SCLK strobes,
// drives a req/ack SRAM port and serialises read data, with optional burst auto-increment.
module spi_sram_seq #(
    parameter int               CMD_W     = 8,
    parameter int               ADDR_W    = 8,
    parameter int               DATA_W    = 8,
    parameter logic [CMD_W-1:0] READ_CMD  = 8'h03,
    parameter logic [CMD_W-1:0] WRITE_CMD = 8'h02,
    parameter bit               BURST_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_n,
    input  logic              sclk_rise,
    input  logic              sclk_fall,
    input  logic              mosi,
    output logic              miso,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              cmd_err,
    output logic              ovr
);
    localparam int MAX_W = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                            : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
    localparam int CNT_W = $clog2(MAX_W + 1);
    localparam logic [CNT_W-1:0] CMD_N  = CNT_W'(CMD_W);
    localparam logic [CNT_W-1:0] ADDR_N = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] DATA_N = CNT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_WR_MEM, S_RD_MEM, S_RD_DATA, S_IGNORE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [MAX_W-1:0]   sh_q, sh_d, sh_shift;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  tx_q, tx_d;
    logic               miso_q, miso_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic               cmd_err_q, cmd_err_d;
    logic               ovr_q, ovr_d;
    logic               ack_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        cmd_err_d = 1'b0;
        ovr_d     = 1'b0;
        cnt_inc   = cnt_q + 1'b1;
        sh_shift  = {sh_q[MAX_W-2:0], mosi};
        ack_ok    = mem_ack & req_q;

        case (state_q)
            S_IDLE: if (!cs_n) begin
                state_d = S_CMD;
                cnt_d   = '0;
            end
            S_CMD: if (cs_n) state_d = S_IDLE;
            else if (sclk_rise) begin
                sh_d  = sh_shift;
                cnt_d = cnt_inc;
                if (cnt_inc == CMD_N) begin
                    cnt_d = '0;
                    if (sh_shift[CMD_W-1:0] == READ_CMD) begin
                        rd_d    = 1'b1;
                        state_d = S_ADDR;
                    end else if (sh_shift[CMD_W-1:0] == WRITE_CMD) begin
                        rd_d    = 1'b0;
                        state_d = S_ADDR;
                    end else begin
                        state_d   = S_IGNORE;
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_ADDR: if (cs_n) state_d = S_IDLE;
            else if (sclk_rise) begin
                sh_d  = sh_shift;
                cnt_d = cnt_inc;
                if (cnt_inc == ADDR_N) begin
                    cnt_d   = '0;
                    addr_d  = sh_shift[ADDR_W-1:0];
                    state_d = rd_q ? S_RD_MEM : S_WR_DATA;
                end
            end
            S_WR_DATA: if (cs_n) state_d = S_IDLE;
            else if (sclk_rise) begin
                sh_d  = sh_shift;
                cnt_d = cnt_inc;
                if (cnt_inc == DATA_N) begin
                    cnt_d   = '0;
                    wdata_d = sh_shift[DATA_W-1:0];
                    state_d = S_WR_MEM;
                end
            end
            // Memory states hold the request until ack even if the frame ends.
            S_WR_MEM: begin
                ovr_d = sclk_rise;
                if (ack_ok) begin
                    cnt_d = '0;
                    if (cs_n) state_d = S_IDLE;
                    else if (BURST_EN) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_WR_DATA;
                    end else state_d = S_IGNORE;
                end
            end
            S_RD_MEM: begin
                ovr_d = sclk_rise;
                if (ack_ok) begin
                    cnt_d   = '0;
                    tx_d    = mem_rdata;
                    state_d = cs_n ? S_IDLE : S_RD_DATA;
                end
            end
            S_RD_DATA: if (cs_n) state_d = S_IDLE;
            else begin
                // The MSB is already on miso after load; the first fall of a word is not a shift.
                if (sclk_fall && cnt_q != '0) tx_d = tx_q << 1;
                if (sclk_rise) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == DATA_N) begin
                        cnt_d = '0;
                        if (BURST_EN) begin
                            addr_d  = addr_q + 1'b1;
                            state_d = S_RD_MEM;
                        end else state_d = S_IGNORE;
                    end
                end
            end
            S_IGNORE: if (cs_n) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        req_d  = (state_d == S_WR_MEM) || (state_d == S_RD_MEM);
        we_d   = (state_d == S_WR_MEM);
        miso_d = (state_d == S_RD_DATA) ? tx_d[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            rd_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            cmd_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            req_q     <= req_d;
            we_q      <= we_d;
            cmd_err_q <= cmd_err_d;
            ovr_q     <= ovr_d;
        end
    end

    assign miso      = miso_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign cmd_err   = cmd_err_q;
    assign ovr       = ovr_q;
endmodule

// File: tb/tb_spi_sram_seq.sv
// Bench for spi_sram_seq: two instances (BURST_EN=0 at index 0, BURST_EN=1 at index 1) share one
// SPI master; each has its own SRAM responder and a frame-level reference model.
module tb_spi_sram_seq;
    logic       clk, rst, cs_n, sclk_rise, sclk_fall, mosi;
    logic       miso[2], mem_req[2], mem_we[2], mem_ack[2], busy[2], cmd_err[2], ovr[2];
    logic [7:0] mem_addr[2], mem_wdata[2], mem_rdata[2];

    int checks = 0, errors = 0;

    spi_sram_seq #(.BURST_EN(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .mosi(mosi), .miso(miso[0]), .mem_req(mem_req[0]), .mem_we(mem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .mem_ack(mem_ack[0]), .busy(busy[0]), .cmd_err(cmd_err[0]), .ovr(ovr[0]));
    spi_sram_seq #(.BURST_EN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .cs_n(cs_n), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .mosi(mosi), .miso(miso[1]), .mem_req(mem_req[1]), .mem_we(mem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .mem_ack(mem_ack[1]), .busy(busy[1]), .cmd_err(cmd_err[1]), .ovr(ovr[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM responders and access logs
    logic [7:0] sram[2][256];
    logic [7:0] refm[2][256];
    logic       lg_we[2][1024];
    logic [7:0] lg_addr[2][1024], lg_wd[2][1024];
    int         lg_n[2], wc[2];
    int         ack_dly = 0;
    logic       ack_hold = 1'b0;
    int         n_err[2], n_ovr[2];

    initial begin
        lg_n = '{0, 0}; wc = '{0, 0};
        mem_ack = '{1'b0, 1'b0}; mem_rdata = '{8'h00, 8'h00};
        forever begin
            @(posedge clk); #1;
            for (int g = 0; g < 2; g++) begin
                if (mem_ack[g]) begin
                    mem_ack[g] = 1'b0; wc[g] = 0;
                end else if (mem_req[g] && !ack_hold) begin
                    if (wc[g] >= ack_dly) begin
                        mem_ack[g]   = 1'b1;
                        mem_rdata[g] = sram[g][mem_addr[g]];
                        if (lg_n[g] < 1024) begin
                            lg_we[g][lg_n[g]]   = mem_we[g];
                            lg_addr[g][lg_n[g]] = mem_addr[g];
                            lg_wd[g][lg_n[g]]   = mem_wdata[g];
                            lg_n[g]++;
                        end
                        if (mem_we[g]) sram[g][mem_addr[g]] = mem_wdata[g];
                        wc[g] = 0;
                    end else wc[g]++;
                end else wc[g] = 0;
            end
        end
    end

    initial begin
        n_err = '{0, 0}; n_ovr = '{0, 0};
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (cmd_err[g]) n_err[g]++;
                if (ovr[g]) n_ovr[g]++;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // SPI master: miso is captured just before each rising strobe
    logic [7:0] fr[8];
    int         fr_len;
    logic [7:0] rx[2][8];

    task automatic spi_bit(input logic b, output logic m0, output logic m1);
        m0 = miso[0]; m1 = miso[1];
        mosi = b; sclk_rise = 1'b1; tick();
        sclk_rise = 1'b0; tick();
        sclk_fall = 1'b1; tick();
        sclk_fall = 1'b0; tick();
    endtask

    task automatic spi_byte(input int k);
        logic m0, m1;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(fr[k][i], m0, m1);
            rx[0][k][i] = m0; rx[1][k][i] = m1;
        end
        repeat (8) tick();
    endtask

    task automatic run_frame();
        cs_n = 1'b0; tick();
        for (int k = 0; k < fr_len; k++) spi_byte(k);
        cs_n = 1'b1; tick(); tick();
    endtask

    // Reference model: whole-frame outcome from the protocol rules
    int         e_n, e_err;
    logic       e_we[16];
    logic [7:0] e_addr[16], e_wd[16], e_rx[8];

    task automatic model_frame(input int g);
        logic [7:0] a;
        int nrd;
        e_n = 0; e_err = 0;
        for (int k = 0; k < 8; k++) e_rx[k] = 8'h00;
        if (fr[0] != 8'h02 && fr[0] != 8'h03) e_err = 1;
        else if (fr_len >= 2) begin
            a = fr[1];
            if (fr[0] == 8'h02) begin
                for (int k = 2; k < fr_len; k++) if (g == 1 || k == 2) begin
                    refm[g][a] = fr[k];
                    e_we[e_n] = 1'b1; e_addr[e_n] = a; e_wd[e_n] = fr[k]; e_n++;
                    a = a + 8'd1;
                end
            end else begin
                nrd = (g == 1) ? fr_len - 1 : 1;
                for (int j = 0; j < nrd; j++) begin
                    e_we[e_n] = 1'b0; e_addr[e_n] = a + 8'(j); e_wd[e_n] = 8'h00; e_n++;
                end
                for (int k = 2; k < fr_len; k++)
                    if (g == 1 || k == 2) e_rx[k] = refm[g][a + 8'(k - 2)];
            end
        end
    endtask

    task automatic frame_checked();
        int base[2], ebase[2];
        for (int g = 0; g < 2; g++) begin base[g] = lg_n[g]; ebase[g] = n_err[g]; end
        run_frame();
        for (int g = 0; g < 2; g++) begin
            model_frame(g);
            chk($sformatf("txn_count[%0d]", g), lg_n[g] - base[g], e_n);
            for (int j = 0; j < e_n && base[g] + j < lg_n[g]; j++) begin
                chk($sformatf("txn_we[%0d].%0d", g, j), lg_we[g][base[g]+j], e_we[j]);
                chk($sformatf("txn_addr[%0d].%0d", g, j), lg_addr[g][base[g]+j], e_addr[j]);
                if (e_we[j]) chk($sformatf("txn_wdata[%0d].%0d", g, j), lg_wd[g][base[g]+j], e_wd[j]);
            end
            for (int k = 0; k < fr_len; k++)
                chk($sformatf("miso_byte[%0d].%0d", g, k), rx[g][k], e_rx[k]);
            chk($sformatf("cmd_err_pulses[%0d]", g), n_err[g] - ebase[g], e_err);
            chk($sformatf("busy_after_frame[%0d]", g), busy[g], 0);
        end
    endtask

    typedef struct {
        int         len;
        logic [7:0] b[4];
        int         ntx[2];
        int         nerr;
    } vec_t;
    vec_t vt[7];

    initial begin
        int   b0[2], o0[2], e0[2];
        logic [7:0] v;
        rst = 1'b0; cs_n = 1'b1; sclk_rise = 1'b0; sclk_fall = 1'b0; mosi = 1'b0;
        for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            sram[0][a] = v; sram[1][a] = v; refm[0][a] = v; refm[1][a] = v;
        end
        vt[0] = '{3, '{8'h02, 8'h10, 8'hA5, 8'h00}, '{1, 1}, 0};
        vt[1] = '{4, '{8'h03, 8'hFF, 8'h00, 8'h00}, '{1, 3}, 0};
        vt[2] = '{1, '{8'h5A, 8'h00, 8'h00, 8'h00}, '{0, 0}, 1};
        vt[3] = '{4, '{8'h02, 8'h20, 8'h11, 8'h22}, '{1, 2}, 0};
        vt[4] = '{2, '{8'h03, 8'h40, 8'h00, 8'h00}, '{1, 1}, 0};
        vt[5] = '{2, '{8'h02, 8'h30, 8'h00, 8'h00}, '{0, 0}, 0};
        vt[6] = '{3, '{8'hFF, 8'h02, 8'h10, 8'h00}, '{0, 0}, 1};

        repeat (3) tick();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset_busy[%0d]", g), busy[g], 0);
            chk($sformatf("reset_req[%0d]", g), mem_req[g], 0);
            chk($sformatf("reset_miso[%0d]", g), miso[g], 0);
            chk($sformatf("reset_addr[%0d]", g), mem_addr[g], 0);
        end
        rst = 1'b1; tick();

        // Table vectors: hand-derived transaction and error counts
        for (int i = 0; i < 7; i++) begin
            fr_len = vt[i].len;
            for (int k = 0; k < 4; k++) fr[k] = vt[i].b[k];
            for (int g = 0; g < 2; g++) begin b0[g] = lg_n[g]; e0[g] = n_err[g]; end
            ack_dly = i % 3;
            frame_checked();
            for (int g = 0; g < 2; g++) begin
                chk($sformatf("vec%0d_ntx[%0d]", i, g), lg_n[g] - b0[g], vt[i].ntx[g]);
                chk($sformatf("vec%0d_nerr[%0d]", i, g), n_err[g] - e0[g], vt[i].nerr);
            end
        end

        // Read across the top of memory with fixed data
        for (int g = 0; g < 2; g++) begin
            sram[g][8'hFF] = 8'h3C; refm[g][8'hFF] = 8'h3C;
            sram[g][8'h00] = 8'h7E; refm[g][8'h00] = 8'h7E;
        end
        ack_dly = 2; fr_len = 4; fr[0] = 8'h03; fr[1] = 8'hFF; fr[2] = 8'h00; fr[3] = 8'h00;
        b0[1] = lg_n[1];
        frame_checked();
        chk("wrap_byte0", rx[1][2], 8'h3C);
        chk("wrap_byte1", rx[1][3], 8'h7E);
        chk("wrap_addr", lg_addr[1][b0[1]+1], 8'h00);

        // Frame aborted after 4 address bits
        for (int g = 0; g < 2; g++) b0[g] = lg_n[g];
        fr[0] = 8'h02; fr[1] = 8'hC3;
        cs_n = 1'b0; tick();
        spi_byte(0);
        for (int i = 7; i >= 4; i--) begin
            logic m0, m1;
            spi_bit(fr[1][i], m0, m1);
        end
        cs_n = 1'b1; tick();
        for (int g = 0; g < 2; g++) chk($sformatf("abort_busy[%0d]", g), busy[g], 0);
        tick();
        for (int g = 0; g < 2; g++) chk($sformatf("abort_no_req[%0d]", g), lg_n[g] - b0[g], 0);
        fr_len = 3; fr[0] = 8'h03; fr[1] = 8'h21; fr[2] = 8'h00;
        frame_checked();

        // Held-off ack with an sclk rise during the write access
        ack_hold = 1'b1;
        for (int g = 0; g < 2; g++) begin b0[g] = lg_n[g]; o0[g] = n_ovr[g]; end
        fr[0] = 8'h02; fr[1] = 8'h50; fr[2] = 8'h66;
        cs_n = 1'b0; tick();
        for (int k = 0; k < 3; k++) spi_byte(k);
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("hold_req[%0d]", g), mem_req[g], 1);
            chk($sformatf("hold_we[%0d]", g), mem_we[g], 1);
            chk($sformatf("hold_addr[%0d]", g), mem_addr[g], 8'h50);
            chk($sformatf("hold_wdata[%0d]", g), mem_wdata[g], 8'h66);
        end
        sclk_rise = 1'b1; mosi = 1'b1; tick();
        sclk_rise = 1'b0; tick(); tick();
        for (int g = 0; g < 2; g++) chk($sformatf("ovr_pulse[%0d]", g), n_ovr[g] - o0[g], 1);
        ack_hold = 1'b0;
        repeat (5) tick();
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("hold_txn[%0d]", g), lg_n[g] - b0[g], 1);
            refm[g][8'h50] = 8'h66;
        end
        cs_n = 1'b1; tick(); tick();

        // Asynchronous reset while a read access is pending
        ack_hold = 1'b1;
        fr[0] = 8'h03; fr[1] = 8'h70;
        cs_n = 1'b0; tick();
        spi_byte(0); spi_byte(1);
        for (int g = 0; g < 2; g++) chk($sformatf("rdmem_req[%0d]", g), mem_req[g], 1);
        #2 rst = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("arst_busy[%0d]", g), busy[g], 0);
            chk($sformatf("arst_req[%0d]", g), mem_req[g], 0);
            chk($sformatf("arst_we[%0d]", g), mem_we[g], 0);
            chk($sformatf("arst_addr[%0d]", g), mem_addr[g], 0);
            chk($sformatf("arst_wdata[%0d]", g), mem_wdata[g], 0);
            chk($sformatf("arst_miso[%0d]", g), miso[g], 0);
        end
        cs_n = 1'b1; tick(); tick();
        ack_hold = 1'b0; rst = 1'b1; tick();

        // Randomised frames against the model
        for (int f = 0; f < 30; f++) begin
            int r;
            r = int'($urandom_range(0, 4));
            fr_len = int'($urandom_range(1, 5));
            fr[0] = (r < 2) ? 8'h02 : (r < 4) ? 8'h03 : 8'($urandom);
            for (int k = 1; k < 8; k++) fr[k] = 8'($urandom);
            ack_dly = int'($urandom_range(0, 3));
            frame_checked();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
